// File: rtl/enc_frame_arbiter.sv
// Round-robin frame scheduler sharing one RS encoder between CH_NUM message channels.
// A channel keeps its grant for a whole MES_LEN-symbol frame; a short gap follows each frame.
module enc_frame_arbiter #(
  parameter  int SYM_WID = 8,
  parameter  int ENC_SYM = 16,
  parameter  int MES_LEN = 223,
  parameter  int CH_NUM  = 4,
  parameter  int GAP_CYC = 2,
  localparam int BEAT_W  = ENC_SYM * SYM_WID,
  localparam int CNT_W   = $clog2(ENC_SYM + 1),
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        req_valid,
  input  logic [CH_NUM*BEAT_W-1:0] req_data,
  output logic [CH_NUM-1:0]        req_ready,
  input  logic                     enc_stall,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [BEAT_W-1:0]        out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_first,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_chan,
  output logic                     frame_done,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int REM       = MES_LEN % ENC_SYM;
  localparam int FIRST_CNT = (REM == 0) ? ENC_SYM : REM;
  localparam int BEATS     = (MES_LEN + ENC_SYM - 1) / ENC_SYM;
  localparam int BEAT_CW   = $clog2(BEATS + 1);
  localparam int GAP_W     = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]      gnt_q, gnt_d;
  logic [BEAT_CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 busy_q, busy_d;

  logic                 any_req;
  logic [CH_W-1:0]      pick;
  logic                 in_xfer;
  logic                 last_beat;
  logic                 sel_valid;
  logic [BEAT_W-1:0]    sel_data;
  logic                 xfer;

  // Round-robin search: first requesting channel at or above rr_ptr, wrapping modulo CH_NUM.
  always_comb begin
    int idx;
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (!any_req && req_valid[idx[CH_W-1:0]]) begin
        any_req = 1'b1;
        pick    = idx[CH_W-1:0];
      end
    end
  end

  assign in_xfer   = (state_q == XFER);
  assign last_beat = (beat_cnt_q == BEAT_CW'(BEATS - 1));
  assign sel_valid = req_valid[gnt_q];
  assign sel_data  = req_data[int'(gnt_q)*BEAT_W +: BEAT_W];

  // Handshake: a beat moves when out_valid & out_ready; enc_stall masks both
  // out_valid and the granted req_ready, so a stall always wins over out_ready.
  assign out_valid = in_xfer & sel_valid & ~enc_stall;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    req_ready = '0;
    if (in_xfer) req_ready[gnt_q] = out_ready & ~enc_stall;
  end

  assign out_data   = in_xfer ? sel_data : '0;
  assign out_first  = in_xfer & (beat_cnt_q == '0);
  assign out_last   = in_xfer & last_beat;
  assign out_count  = !in_xfer ? '0 :
                      (beat_cnt_q == '0) ? CNT_W'(FIRST_CNT) : CNT_W'(ENC_SYM);
  assign out_chan   = gnt_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    beat_cnt_d   = beat_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      ARB: begin
        if (any_req) begin
          gnt_d      = pick;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BEAT_CW'(1);
          if (last_beat) begin
            rr_ptr_d     = (gnt_q == CH_W'(CH_NUM - 1)) ? '0 : gnt_q + CH_W'(1);
            frame_done_d = 1'b1;
            gap_cnt_d    = GAP_W'(GAP_CYC - 1);
            state_d      = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = ARB;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = ARB;
    endcase
    busy_d = (state_d != ARB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      beat_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      beat_cnt_q   <= beat_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_valid_in_xfer: assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> in_xfer);
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                  in_xfer |-> beat_cnt_q < BEAT_CW'(BEATS));

endmodule

// File: tb/tb_enc_frame_arbiter.sv
// Bench for enc_frame_arbiter: directed scenarios plus random traffic, checked cycle by
// cycle against a frame-level reference model and a grant-order scoreboard.
module tb_enc_frame_arbiter;

  localparam int SYM_WID = 8;
  localparam int ENC_SYM = 16;
  localparam int MES_LEN = 223;
  localparam int CH_NUM  = 4;
  localparam int GAP_CYC = 2;
  localparam int DW      = ENC_SYM * SYM_WID;
  localparam int BEATS   = (MES_LEN + ENC_SYM - 1) / ENC_SYM;
  localparam int FIRST_N = MES_LEN - (BEATS - 1) * ENC_SYM;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  logic [CH_NUM-1:0]    req_valid;
  logic [CH_NUM*DW-1:0] req_data;
  logic [CH_NUM-1:0]    req_ready;
  logic                 enc_stall, out_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [4:0]           out_count;
  logic                 out_first, out_last;
  logic [1:0]           out_chan;
  logic                 frame_done, busy;
  logic [1:0]           dbg_state;

  enc_frame_arbiter #(.SYM_WID(SYM_WID), .ENC_SYM(ENC_SYM), .MES_LEN(MES_LEN),
                      .CH_NUM(CH_NUM), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_stall(enc_stall), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_first(out_first), .out_last(out_last), .out_chan(out_chan),
    .frame_done(frame_done), .busy(busy), .dbg_state(dbg_state));

  // MES_LEN=224 variant: no partial beat
  logic                 v_rst_n;
  logic [CH_NUM-1:0]    v_req_valid;
  logic [CH_NUM*DW-1:0] v_req_data;
  logic [CH_NUM-1:0]    v_req_ready;
  logic                 v_enc_stall, v_out_ready;
  logic                 v_out_valid;
  logic [DW-1:0]        v_out_data;
  logic [4:0]           v_out_count;
  logic                 v_out_first, v_out_last;
  logic [1:0]           v_out_chan;
  logic                 v_frame_done, v_busy;
  logic [1:0]           v_dbg_state;

  enc_frame_arbiter #(.SYM_WID(SYM_WID), .ENC_SYM(ENC_SYM), .MES_LEN(224),
                      .CH_NUM(CH_NUM), .GAP_CYC(GAP_CYC)) dut_v (
    .clk(clk), .rst_n(v_rst_n), .req_valid(v_req_valid), .req_data(v_req_data),
    .req_ready(v_req_ready), .enc_stall(v_enc_stall), .out_ready(v_out_ready),
    .out_valid(v_out_valid), .out_data(v_out_data), .out_count(v_out_count),
    .out_first(v_out_first), .out_last(v_out_last), .out_chan(v_out_chan),
    .frame_done(v_frame_done), .busy(v_busy), .dbg_state(v_dbg_state));

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got_gnts[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: frame owner (-1 = none), beats sent, gap cycles left, rr pointer
  int   m_owner, m_sent, m_gap, m_ptr, m_gnt;
  logic m_done;

  task automatic model_reset();
    m_owner = -1; m_sent = 0; m_gap = 0; m_ptr = 0; m_gnt = 0; m_done = 1'b0;
    exp_q.delete();
    got_gnts.delete();
  endtask

  task automatic rand_data();
    for (int i = 0; i < CH_NUM * DW / 32; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_valid"}, out_valid, 0);
    chk({pfx, "_ready"}, req_ready, 0);
    chk({pfx, "_busy"},  busy, 0);
    chk({pfx, "_done"},  frame_done, 0);
    chk({pfx, "_chan"},  out_chan, 0);
    chk({pfx, "_count"}, out_count, 0);
    chk({pfx, "_first"}, out_first, 0);
    chk({pfx, "_last"},  out_last, 0);
    chk({pfx, "_data"},  out_data, 0);
  endtask

  // One clock: compare at negedge against the model, then advance the model.
  task automatic step();
    bit            in_frame, e_valid, moved;
    logic [3:0]    e_ready;
    logic [DW-1:0] e_data;
    logic [1:0]    eg;
    @(negedge clk);
    in_frame = (m_owner >= 0);
    e_valid  = in_frame && req_valid[m_owner] && !enc_stall;
    e_ready  = '0;
    e_data   = '0;
    if (in_frame) begin
      e_ready[m_owner] = out_ready && !enc_stall;
      e_data = req_data[m_owner*DW +: DW];
    end
    chk("out_valid", out_valid, e_valid);
    chk("req_ready", req_ready, e_ready);
    chk("out_data", out_data, e_data);
    chk("out_count", out_count, !in_frame ? 0 : (m_sent == 0 ? FIRST_N : ENC_SYM));
    chk("out_first", out_first, in_frame && m_sent == 0);
    chk("out_last", out_last, in_frame && m_sent == BEATS - 1);
    chk("out_chan", out_chan, m_gnt);
    chk("busy", busy, in_frame || m_gap > 0);
    chk("frame_done", frame_done, m_done);
    if (out_valid && out_ready && out_first) begin
      eg = 2'bxx;
      if (exp_q.size() > 0) eg = exp_q.pop_front();
      chk("gnt_order", out_chan, eg);
      got_gnts.push_back(out_chan);
    end
    moved  = e_valid && out_ready;
    m_done = 1'b0;
    if (in_frame) begin
      if (moved) begin
        m_sent++;
        if (m_sent == BEATS) begin
          m_ptr   = (m_owner + 1) % CH_NUM;
          m_owner = -1;
          m_gap   = GAP_CYC;
          m_done  = 1'b1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (m_owner < 0 && req_valid[(m_ptr + i) % CH_NUM]) begin
          m_owner = (m_ptr + i) % CH_NUM;
          m_gnt   = m_owner;
          m_sent  = 0;
          exp_q.push_back(2'(m_owner));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; enc_stall = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_sent(input int target, input string tag);
    for (int c = 0; c < 60 && !(m_owner >= 0 && m_sent == target); c++) begin
      rand_data();
      step();
    end
    chk(tag, m_sent, target);
  endtask

  int n_fd, beats, last_at;
  logic [1:0] want [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; enc_stall = 1'b0; out_ready = 1'b0;
    v_rst_n = 1'b0; v_req_valid = '0; v_req_data = '0; v_enc_stall = 1'b0; v_out_ready = 1'b0;
    model_reset();
    #12;
    chk_zero_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1; v_rst_n = 1'b1;

    // single channel, always ready
    req_valid = 4'b0001; out_ready = 1'b1;
    n_fd = 0;
    for (int c = 0; c < 20; c++) begin
      rand_data();
      step();
      if (frame_done) n_fd++;
    end
    chk("t1_frames", n_fd, 1);

    // all channels valid: grants 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 72; c++) begin
      rand_data();
      step();
    end
    want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    chk("t2_nframes", got_gnts.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", (got_gnts.size() > i) ? got_gnts[i] : 2'bxx, want[i]);

    // encoder stall for 3 cycles at beat 5
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b1;
    run_until_sent(5, "t3_reach");
    enc_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_held", m_sent, 5);
    end
    enc_stall = 1'b0;
    for (int c = 0; c < 12; c++) begin rand_data(); step(); end

    // ch2 drops valid mid-frame while ch1 requests
    do_reset();
    req_valid = 4'b0100; out_ready = 1'b1;
    run_until_sent(4, "t4_reach");
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      rand_data();
      step();
      chk("t4_no_ch1_ready", req_ready[1], 0);
    end
    req_valid = 4'b0110;
    for (int c = 0; c < 18; c++) begin rand_data(); step(); end
    chk("t4_next_gnt", out_chan, 1);

    // reset at beat 7 of a ch3 frame
    do_reset();
    req_valid = 4'b1000; out_ready = 1'b1;
    run_until_sent(7, "t5_reach");
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("t5_rst");
    model_reset();
    @(posedge clk); #1;
    req_valid = 4'b1010;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin rand_data(); step(); end
    chk("t5_gnt", out_chan, 1);

    // random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rand_data();
      req_valid = 4'($urandom_range(0, 15));
      enc_stall = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 4) != 0);
      step();
    end

    // MES_LEN=224 variant: 14 full beats
    v_req_valid = 4'b0001; v_out_ready = 1'b1;
    for (int i = 0; i < CH_NUM * DW / 32; i++) v_req_data[i*32 +: 32] = $urandom;
    beats = 0; last_at = -1;
    for (int c = 0; c < 40 && last_at < 0; c++) begin
      @(negedge clk);
      if (v_out_valid && v_out_ready) begin
        chk("v_count", v_out_count, 16);
        chk("v_first", v_out_first, beats == 0);
        if (v_out_last) last_at = beats + 1;
        beats++;
      end
    end
    chk("v_beats", last_at, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enc_frame_arbiter.md
Name: enc_frame_arbiter

Overview:
- Input-side scheduler for the RS encoder. Shares one encoder between CH_NUM message channels.
- Grants one channel for a whole message frame of MES_LEN symbols, using round-robin order.
- Forwards the granted channel's beats to the encoder with a zero-latency valid/ready pass-through.
- Honours the encoder stall, then holds a fixed inter-frame gap so the parity can drain.

Parameters:
- SYM_WID, 8, bits per symbol.
- ENC_SYM, 16, symbols per beat.
- MES_LEN, 223, message symbols per frame.
- CH_NUM, 4, number of requesting channels (≥2).
- GAP_CYC, 2, idle cycles inserted after each frame's last beat (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  CH_NUM  per-channel beat valid.
- req_data  in  CH_NUM×ENC_SYM×SYM_WID  per-channel beat; symbols are packed in the low positions.
- req_ready  out  CH_NUM  per-channel beat accepted.
- enc_stall  in  1  encoder stall; no beat is consumed while high.
- out_ready  in  1  encoder can accept a beat.
- out_valid  out  1  beat presented to the encoder.
- out_data  out  ENC_SYM×SYM_WID  beat forwarded from the granted channel.
- out_count  out  $clog2(ENC_SYM+1)  number of valid symbols in the current beat.
- out_first  out  1  first beat of the frame.
- out_last  out  1  last beat of the frame.
- out_chan  out  max(1,$clog2(CH_NUM))  granted channel index.
- frame_done  out  1  one-cycle pulse after a frame's last beat transfers.
- busy  out  1  high in XFER and GAP.

Behaviour:
- Derived constants:
  - REM = MES_LEN % ENC_SYM.
  - FIRST_CNT = (REM==0) ? ENC_SYM : REM.
  - BEATS = ceil(MES_LEN/ENC_SYM).
  - The partial beat is always first, matching the encoder's partial-first processing.
- Transfer condition: xfer = out_valid & out_ready.
- States: ARB, XFER, GAP. Reset state is ARB.
- Reset values:
  - All registered outputs are 0: rr_ptr=0, gnt=0, beat_cnt=0, gap_cnt=0, frame_done=0, busy=0.
  - Combinational outputs decode from state, so out_valid=0 and req_ready=0 under reset.
- ARB:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward, with modulo CH_NUM wrap.
  - Latch gnt, clear beat_cnt, move to XFER next cycle. Arbitration costs 1 cycle.
  - With no requests, stay in ARB.
  - No ready is asserted in ARB.
- XFER:
  - out_valid = req_valid[gnt] & ~enc_stall.
  - req_ready[gnt] = out_ready & ~enc_stall. All other req_ready bits are 0.
  - out_data = req_data[gnt], combinational with zero latency.
  - out_count = FIRST_CNT when beat_cnt==0, else ENC_SYM.
  - out_first = (beat_cnt==0). out_last = (beat_cnt==BEATS-1).
  - beat_cnt increments on xfer only.
  - On xfer with out_last high:
    - set rr_ptr = (gnt+1) mod CH_NUM;
    - pulse frame_done the next cycle;
    - load gap_cnt = GAP_CYC-1;
    - move to GAP.
- Stalls inside a frame:
  - enc_stall high or req_valid low holds state. There is no timeout.
  - The grant is never revoked mid-frame.
- GAP:
  - out_valid=0, all req_ready=0.
  - gap_cnt decrements each cycle; at 0, move to ARB.
- out_chan = gnt in all states; the value only has meaning while busy.
- Simultaneous events: enc_stall and out_ready both high gives no transfer, and enc_stall wins.
- A request on a non-granted channel never affects the current frame.
- Widths:
  - beat_cnt is $clog2(BEATS+1) bits.
  - gap_cnt is $clog2(GAP_CYC+1) bits.
  - rr_ptr wraps explicitly; there is no reliance on power-of-2 CH_NUM.
- Reset mid-frame:
  - Asynchronous return to ARB with rr_ptr=0. The partial frame is abandoned.
  - The first post-reset grant goes to the lowest valid channel.

Test Plan:
- Single channel: ch0 streams 14 beats with out_ready=1.
  - Expect ARB cycle, then out_count 15 on beat 0 and 16 on beats 1..13.
  - Expect out_first on beat 0, out_last on beat 13, frame_done 1 cycle later, then 2 GAP cycles.
- All four channels valid continuously.
  - Expect grants in order 0,1,2,3,0.
  - Each frame is exactly 14 transfers, with a 3-cycle gap (frame_done→ARB) between frames.
- enc_stall high for 3 cycles at beat 5.
  - Expect out_valid=0 and req_ready=0 during the stall.
  - Expect beat_cnt held and the frame still ending at the 14th transfer.
- ch2 drops req_valid mid-frame while ch1 is requesting.
  - Expect the grant to stay on ch2 with no ch1 ready until ch2 finishes its frame.
- rst_n asserted at beat 7 of a ch3 frame, then released with ch1 and ch3 valid.
  - Expect all outputs 0 immediately, then a grant to ch1 with beat_cnt restarting at 0.
- Parameter variant MES_LEN=224, ENC_SYM=16.
  - Expect 14 beats, each with out_count=16.
